// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART register-command parser:
// FSM state encoding, ASCII character constants and error codes.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_ADDR_LO = 3'd2,
    ST_EQ      = 3'd3,
    ST_DATA    = 3'd4,
    ST_END     = 3'd5,
    ST_SKIP    = 3'd6
  } state_t;

  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_SP   = 8'h20;
  localparam logic [7:0] CH_EQ   = 8'h3D;
  localparam logic [7:0] CH_W_UC = 8'h57;
  localparam logic [7:0] CH_W_LC = 8'h77;
  localparam logic [7:0] CH_R_UC = 8'h52;
  localparam logic [7:0] CH_R_LC = 8'h72;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_BAD_CHAR = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

endpackage

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII hex digit decoder.
// Ports:
//   char   in  8  ASCII byte
//   valid  out 1  byte is 0-9, A-F or a-f
//   nibble out 4  decoded value (0 when not valid)
module hex_ascii_decode (
  input  logic [7:0] char,
  output logic       valid,
  output logic [3:0] nibble
);

  always_comb begin
    valid  = 1'b0;
    nibble = 4'h0;
    if (char >= 8'h30 && char <= 8'h39) begin
      valid  = 1'b1;
      nibble = char[3:0];
    end else if ((char >= 8'h41 && char <= 8'h46) ||
                 (char >= 8'h61 && char <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so adding 9 yields 10..15.
      valid  = 1'b1;
      nibble = char[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII register command parser for the host UART link.
// Accepts "Waa=dddd<CR>" and "Raa<CR>" and produces one-cycle strobes.
// Ports:
//   CLK_10MHZ in  system clock
//   rst_n     in  async active-low reset
//   rx_data   in  received byte, valid with rx_ready
//   rx_ready  in  one-cycle byte strobe
//   reg_wr / reg_rd     out  one-cycle completion strobes
//   reg_addr / reg_wdata out held decoded address / write data
//   cmd_err / err_code  out  one-cycle error strobe / held error code
//   busy      out  parser is mid-command
//   cmd_cnt   out  completed commands (wraps)
//   err_cnt   out  errors (saturates at 255)
//
// state   | meaning
// IDLE    | waiting for W/R, whitespace ignored
// ADDR_HI | expecting address high nibble
// ADDR_LO | expecting address low nibble
// EQ      | expecting '=' (writes only)
// DATA    | collecting 4 data nibbles, MSB first
// END     | expecting CR to complete
// SKIP    | discarding until CR/LF after an error
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic        CLK_10MHZ,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        reg_wr,
  output logic        reg_rd,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        cmd_err,
  output logic [1:0]  err_code,
  output logic        busy,
  output logic [7:0]  cmd_cnt,
  output logic [7:0]  err_cnt
);

  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

  state_t state_q, state_d;
  logic is_wr_q, is_wr_d;
  logic [7:0] addr_sh_q, addr_sh_d;
  logic [15:0] data_sh_q, data_sh_d;
  logic [1:0] nib_cnt_q, nib_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic reg_wr_q, reg_wr_d, reg_rd_q, reg_rd_d, cmd_err_q, cmd_err_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [15:0] reg_wdata_q, reg_wdata_d;
  logic [1:0] err_code_q, err_code_d;
  logic [7:0] cmd_cnt_q, cmd_cnt_d, err_cnt_q, err_cnt_d;

  logic hex_valid;
  logic [3:0] hex_nib;
  logic bad_char, timeout;

  hex_ascii_decode u_hex (
    .char   (rx_data),
    .valid  (hex_valid),
    .nibble (hex_nib)
  );

  always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      is_wr_q     <= 1'b0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      nib_cnt_q   <= '0;
      tmo_q       <= TMO_LOAD;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      err_code_q  <= ERR_NONE;
      cmd_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      nib_cnt_q   <= nib_cnt_d;
      tmo_q       <= tmo_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      cmd_err_q   <= cmd_err_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      err_code_q  <= err_code_d;
      cmd_cnt_q   <= cmd_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    nib_cnt_d   = nib_cnt_q;
    tmo_d       = tmo_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    cmd_err_d   = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    err_code_d  = err_code_q;
    cmd_cnt_d   = cmd_cnt_q;
    err_cnt_d   = err_cnt_q;
    bad_char    = 1'b0;
    timeout     = 1'b0;

    if (rx_ready) begin
      // A byte always restarts the inter-byte timer, even at terminal count.
      tmo_d = TMO_LOAD;
      case (state_q)
        ST_IDLE: begin
          if (rx_data == CH_W_UC || rx_data == CH_W_LC) begin
            state_d = ST_ADDR_HI;
            is_wr_d = 1'b1;
          end else if (rx_data == CH_R_UC || rx_data == CH_R_LC) begin
            state_d = ST_ADDR_HI;
            is_wr_d = 1'b0;
          end else if (rx_data != CH_CR && rx_data != CH_LF && rx_data != CH_SP) begin
            bad_char = 1'b1;
          end
        end
        ST_ADDR_HI, ST_ADDR_LO: begin
          if (hex_valid) begin
            addr_sh_d = {addr_sh_q[3:0], hex_nib};
            if (state_q == ST_ADDR_HI) state_d = ST_ADDR_LO;
            else                       state_d = is_wr_q ? ST_EQ : ST_END;
          end else begin
            bad_char = 1'b1;
          end
        end
        ST_EQ: begin
          if (rx_data == CH_EQ) begin
            state_d   = ST_DATA;
            nib_cnt_d = 2'd0;
          end else begin
            bad_char = 1'b1;
          end
        end
        ST_DATA: begin
          if (hex_valid) begin
            data_sh_d = {data_sh_q[11:0], hex_nib};
            if (nib_cnt_q == 2'd3) state_d = ST_END;
            else                   nib_cnt_d = nib_cnt_q + 2'd1;
          end else begin
            bad_char = 1'b1;
          end
        end
        ST_END: begin
          if (rx_data == CH_CR) begin
            state_d    = ST_IDLE;
            reg_addr_d = addr_sh_q;
            cmd_cnt_d  = cmd_cnt_q + 8'd1;
            if (is_wr_q) begin
              reg_wr_d    = 1'b1;
              reg_wdata_d = data_sh_q;
            end else begin
              reg_rd_d = 1'b1;
            end
          end else begin
            bad_char = 1'b1;
          end
        end
        ST_SKIP: begin
          if (rx_data == CH_CR || rx_data == CH_LF) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tmo_q == '0) begin
        // SKIP already reported its error, so it just falls back silently.
        timeout   = (state_q != ST_SKIP);
        state_d   = ST_IDLE;
        addr_sh_d = '0;
        data_sh_d = '0;
        nib_cnt_d = '0;
        tmo_d     = TMO_LOAD;
      end else begin
        tmo_d = tmo_q - 1'b1;
      end
    end else begin
      tmo_d = TMO_LOAD;
    end

    if (bad_char || timeout) begin
      cmd_err_d  = 1'b1;
      err_code_d = timeout ? ERR_TIMEOUT : ERR_BAD_CHAR;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
    if (bad_char) state_d = ST_SKIP;
  end

  assign reg_wr    = reg_wr_q;
  assign reg_rd    = reg_rd_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign cmd_err   = cmd_err_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q != ST_IDLE);
  assign cmd_cnt   = cmd_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed scenarios plus random
// command streams, checked every cycle against a grammar-level model.
module tb_uart_cmd_parser;

  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        reg_wr, reg_rd, cmd_err, busy;
  logic [7:0]  reg_addr, cmd_cnt, err_cnt;
  logic [15:0] reg_wdata;
  logic [1:0]  err_code;

  int n_chk  = 0;
  int n_fail = 0;

  uart_cmd_parser #(.TIMEOUT_CYC(TMO)) dut (
    .CLK_10MHZ (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .cmd_err   (cmd_err),
    .err_code  (err_code),
    .busy      (busy),
    .cmd_cnt   (cmd_cnt),
    .err_cnt   (err_cnt)
  );

  always #50 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]  cur[$];
  bit          skip_m;
  int          idle_n;
  bit          m_wr, m_rd, m_err;
  logic [7:0]  m_addr;
  logic [15:0] m_wdata;
  logic [1:0]  m_code;
  int          m_cmd_cnt, m_err_cnt;

  function automatic int hexval(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    return -1;
  endfunction

  function automatic logic [7:0] hexch(input int v, input bit lc);
    if (v < 10) return 8'(48 + v);
    return lc ? 8'(87 + v) : 8'(55 + v);
  endfunction

  task automatic mdl_reset();
    cur.delete();
    skip_m = 0; idle_n = 0;
    m_wr = 0; m_rd = 0; m_err = 0;
    m_addr = 0; m_wdata = 0; m_code = 0;
    m_cmd_cnt = 0; m_err_cnt = 0;
  endtask

  task automatic mdl_error(input logic [1:0] code);
    m_err = 1;
    m_code = code;
    if (m_err_cnt < 255) m_err_cnt++;
  endtask

  task automatic mdl_byte(input logic [7:0] b);
    bit wr_cmd, fin, ok;
    int p;
    m_wr = 0; m_rd = 0; m_err = 0;
    idle_n = 0;
    if (skip_m) begin
      if (b == 8'h0D || b == 8'h0A) skip_m = 0;
      return;
    end
    if (cur.size() == 0) begin
      if (b == 8'h0D || b == 8'h0A || b == 8'h20) return;
      if (b == 8'h57 || b == 8'h77 || b == 8'h52 || b == 8'h72)
        cur.push_back(b & 8'hDF);
      else begin
        mdl_error(2'b01);
        skip_m = 1;
      end
      return;
    end
    wr_cmd = (cur[0] == 8'h57);
    p = cur.size();
    fin = wr_cmd ? (p == 8) : (p == 3);
    if (fin)                  ok = (b == 8'h0D);
    else if (wr_cmd && p == 3) ok = (b == 8'h3D);
    else                      ok = (hexval(b) >= 0);
    if (!ok) begin
      mdl_error(2'b01);
      skip_m = 1;
      cur.delete();
    end else if (!fin) begin
      cur.push_back(b);
    end else begin
      m_addr = 8'(hexval(cur[1]) * 16 + hexval(cur[2]));
      if (wr_cmd) begin
        m_wdata = 16'(((hexval(cur[4]) * 16 + hexval(cur[5])) * 16
                       + hexval(cur[6])) * 16 + hexval(cur[7]));
        m_wr = 1;
      end else begin
        m_rd = 1;
      end
      m_cmd_cnt = (m_cmd_cnt + 1) % 256;
      cur.delete();
    end
  endtask

  task automatic mdl_idle();
    m_wr = 0; m_rd = 0; m_err = 0;
    idle_n++;
    if ((skip_m || cur.size() != 0) && idle_n == TMO) begin
      if (!skip_m) mdl_error(2'b10);
      skip_m = 0;
      cur.delete();
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".reg_wr"},    32'(reg_wr),    32'(m_wr));
    chk({tag, ".reg_rd"},    32'(reg_rd),    32'(m_rd));
    chk({tag, ".cmd_err"},   32'(cmd_err),   32'(m_err));
    chk({tag, ".reg_addr"},  32'(reg_addr),  32'(m_addr));
    chk({tag, ".reg_wdata"}, 32'(reg_wdata), 32'(m_wdata));
    chk({tag, ".err_code"},  32'(err_code),  32'(m_code));
    chk({tag, ".busy"},      32'(busy),      32'(skip_m || cur.size() != 0));
    chk({tag, ".cmd_cnt"},   32'(cmd_cnt),   32'(m_cmd_cnt));
    chk({tag, ".err_cnt"},   32'(err_cnt),   32'(m_err_cnt));
  endtask

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    rx_data  = 8'($urandom);
    mdl_byte(b);
    check_all("byte");
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      mdl_idle();
      check_all("idle");
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    mdl_reset();
    check_all("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic send_random_cmd();
    logic [7:0] q[$];
    bit is_wr, lc;
    int a, d, gap;
    is_wr = ($urandom_range(0, 1) == 1);
    lc    = ($urandom_range(0, 1) == 1);
    a = $urandom_range(0, 255);
    d = $urandom_range(0, 65535);
    if ($urandom_range(0, 4) == 0) q.push_back($urandom_range(0, 1) ? 8'h20 : 8'h0A);
    q.push_back(is_wr ? (lc ? 8'h77 : 8'h57) : (lc ? 8'h72 : 8'h52));
    q.push_back(hexch(a / 16, $urandom_range(0, 1) == 1));
    q.push_back(hexch(a % 16, $urandom_range(0, 1) == 1));
    if (is_wr) begin
      q.push_back(8'h3D);
      for (int k = 3; k >= 0; k--)
        q.push_back(hexch((d >> (4 * k)) & 15, $urandom_range(0, 1) == 1));
    end
    q.push_back(8'h0D);
    if ($urandom_range(0, 4) == 0) q[$urandom_range(0, q.size() - 1)] = 8'($urandom_range(0, 255));
    if ($urandom_range(0, 5) == 0) q.push_back(8'h0A);
    foreach (q[k]) begin
      send_byte(q[k]);
      gap = ($urandom_range(0, 19) == 0) ? $urandom_range(TMO - 10, TMO + 10)
                                         : $urandom_range(0, 2);
      idle_cyc(gap);
    end
  endtask

  initial begin
    #(100000 * 100);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; rx_ready = 1'b0; rx_data = 8'h00;
    mdl_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    idle_cyc(2);

    send_str("W1A=BEEF\015");
    chk("w1a.addr", 32'(reg_addr), 32'h1A);
    chk("w1a.data", 32'(reg_wdata), 32'hBEEF);
    chk("w1a.cnt",  32'(cmd_cnt), 32'd1);
    idle_cyc(3);

    send_str("r7f\015");
    chk("r7f.addr", 32'(reg_addr), 32'h7F);
    chk("r7f.data", 32'(reg_wdata), 32'hBEEF);
    idle_cyc(2);

    send_str("W1G=0000\015");
    chk("w1g.errcnt", 32'(err_cnt), 32'd1);
    send_str("W01=0001\015");
    chk("w01.data", 32'(reg_wdata), 32'h0001);

    // silence after '=' must end in a timeout error exactly TMO cycles later
    send_str("W12=");
    idle_cyc(TMO + 5);
    chk("tmo.code", 32'(err_code), 32'd2);
    chk("tmo.busy", 32'(busy), 32'd0);

    // byte landing on the terminal-count cycle keeps the command alive
    send_str("W34=");
    idle_cyc(TMO - 1);
    send_str("5678\015");
    chk("edge.data", 32'(reg_wdata), 32'h5678);

    // reset mid-command aborts it; the trailing CR is ignored in IDLE
    send_str("W00=1234");
    pulse_reset();
    send_byte(8'h0D);
    idle_cyc(2);

    for (int i = 0; i < 260; i++) send_str("X\012");
    chk("err.sat", 32'(err_cnt), 32'd255);
    for (int i = 0; i < 256; i++) send_str("R00\015");
    chk("cnt.wrap", 32'(cmd_cnt), 32'd0);

    repeat (150) send_random_cmd();
    idle_cyc(TMO + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
